// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce controller: FSM state encoding and the
// width helper used to size the per-button counters.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LO = 2'd0,
      S_PH = 2'd1,
      S_HI = 2'd2,
      S_PL = 2'd3
   } state_e;

   // Bits needed to hold any value in 0..max_val (at least one bit).
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Sample-rate tick generator: free-running DIV_W-bit counter with a registered
// single-cycle strobe on each wrap. No clock is derived; consumers use the
// strobe as an enable.
module debounce_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_out
);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;

   // Next counter value and wrap detect; the strobe lands in the cycle the counter reads 0.
   always_comb begin
      div_d  = div_q + 1'b1;
      tick_d = &div_q;
   end

   // Counter and strobe registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign tick_out = tick_q;

endmodule

// File: rtl/debounce_ctrl.sv
// Multi-button debounce controller. Each raw input is synchronised, then a
// per-button FSM accepts a level change only after STABLE_CNT consecutive
// agreeing sample ticks, emitting registered press/release pulses.
// Optional auto-repeat of press pulses while held: DEBOUNCE_CTRL_AUTOREPEAT_EN.
//
//   state | meaning
//   S_LO  | level 0, input agrees
//   S_PH  | level 0, input high, counting agreeing ticks toward a press
//   S_HI  | level 1, input agrees (auto-repeat counts here when enabled)
//   S_PL  | level 1, input low, counting agreeing ticks toward a release
module debounce_ctrl
   import debounce_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int DIV_W      = 16,
   parameter int STABLE_CNT = 4
`ifdef DEBOUNCE_CTRL_AUTOREPEAT_EN
   ,
   parameter int REPEAT_TICKS = 64
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             tick_out
);

   localparam int               CNT_W    = cnt_w(STABLE_CNT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

`ifdef DEBOUNCE_CTRL_AUTOREPEAT_EN
   // Repeat timer is a down-counter: loaded on entry to S_HI, fires at zero.
   localparam int               RPT_W    = cnt_w(REPEAT_TICKS);
   localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_TICKS - 1);
`endif

   logic [N_BTN-1:0] sync1_q, sync1_d;
   logic [N_BTN-1:0] sync2_q, sync2_d;

   debounce_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_out (tick_out)
   );

   // Two-stage synchroniser chain for the asynchronous button inputs.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
   end

   // Synchroniser flops; cleared on reset so no stale input survives it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      state_e           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             level_q;
      logic             press_q;
      logic             release_q;
      logic             s;
`ifdef DEBOUNCE_CTRL_AUTOREPEAT_EN
      logic [RPT_W-1:0] rpt_q;
`endif

      assign s = sync2_q[i];

      // Debounce FSM: advances only on sample ticks; pulses are one clk wide.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q   <= S_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef DEBOUNCE_CTRL_AUTOREPEAT_EN
            rpt_q     <= '0;
`endif
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (tick_out) begin
               unique case (state_q)
                  S_LO: begin
                     if (s) begin
                        state_q <= S_PH;
                        cnt_q   <= CNT_ONE;
                     end
                  end
                  S_PH: begin
                     if (!s) begin
                        state_q <= S_LO;
                        cnt_q   <= '0;
                     end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_HI;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
`ifdef DEBOUNCE_CTRL_AUTOREPEAT_EN
                        rpt_q   <= RPT_LOAD;
`endif
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
                  S_HI: begin
                     if (!s) begin
                        // Repeat timer is left as-is; a bounce back reloads it.
                        state_q <= S_PL;
                        cnt_q   <= CNT_ONE;
                     end
`ifdef DEBOUNCE_CTRL_AUTOREPEAT_EN
                     else if (rpt_q == '0) begin
                        press_q <= 1'b1;
                        rpt_q   <= RPT_LOAD;
                     end else begin
                        rpt_q <= rpt_q - 1'b1;
                     end
`endif
                  end
                  S_PL: begin
                     if (s) begin
                        state_q <= S_HI;
                        cnt_q   <= '0;
`ifdef DEBOUNCE_CTRL_AUTOREPEAT_EN
                        rpt_q   <= RPT_LOAD;
`endif
                     end else if (cnt_q == CNT_LAST) begin
                        state_q   <= S_LO;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
`ifdef DEBOUNCE_CTRL_AUTOREPEAT_EN
                        rpt_q     <= '0;
`endif
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               endcase
            end
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;
   end

endmodule
